fifo_byte_drain: RTL and testbench
==================================

Name: fifo_byte_drain

Overview:
- Read-side companion to the team's 16-bit-in/byte-storage FIFO.
- Pops 16-bit words from the FIFO's read port (rd_en / data_out / empty) and serializes each word as two bytes, MSB first, onto a byte-wide valid/ready stream.
- Groups bytes into frames of FRAME_WORDS words and marks the final byte of each frame with tx_last.
- Sits between the FIFO and a byte-oriented downstream consumer (link or serializer).

Parameters:
- FRAME_WORDS, 8, number of 16-bit words per frame; legal range 1..255.
- CNT_W, 8, width of the frame_count wrapping counter.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  drain enable; sampled only in IDLE.
- fifo_empty  input  1  FIFO empty flag (registered in the FIFO).
- fifo_data  input  16  FIFO data_out; valid the cycle after the rd_en pulse.
- fifo_rd_en  output  1  single-cycle read strobe to the FIFO.
- tx_data  output  8  byte to downstream.
- tx_valid  output  1  tx_data/tx_last valid.
- tx_ready  input  1  downstream accepts the byte when tx_valid and tx_ready are both 1 at posedge.
- tx_last  output  1  qualifies the final byte of a frame.
- busy  output  1  high in every state except IDLE.
- frame_count  output  CNT_W  number of completed frames; wraps at 2^CNT_W.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, fifo_rd_en=0, tx_valid=0, tx_data=0, tx_last=0, busy=0, frame_count=0, word index=0, holding register=0.
- Reset mid-operation aborts any in-flight word. The partially sent byte is lost. The FIFO-side pointer state belongs to the FIFO.
- FSM states: IDLE, REQ, CAPT, SEND_HI, SEND_LO.
- IDLE: if en=1 and fifo_empty=0, go to REQ. Otherwise stay.
- REQ: fifo_rd_en=1 for exactly this one cycle. Unconditionally go to CAPT.
- CAPT: at the posedge leaving CAPT, latch fifo_data into the 16-bit holding register. Go to SEND_HI. fifo_empty is not sampled in REQ or CAPT, because the FIFO flag lags the pop by one cycle.
- SEND_HI: tx_valid=1, tx_data=hold[15:8], tx_last=0. On tx_ready, go to SEND_LO. Otherwise hold all outputs stable; no change is allowed while stalled.
- SEND_LO: tx_valid=1, tx_data=hold[7:0], tx_last=1 iff word index==FRAME_WORDS-1.
- SEND_LO handshake:
  - Word index increments, or wraps to 0 at FRAME_WORDS-1.
  - On wrap, frame_count increments.
  - Next state: REQ if en=1 and fifo_empty=0, else IDLE.
- tx_valid, tx_data and tx_last are registered outputs. tx_valid is 0 in IDLE, REQ and CAPT.
- Latency: from IDLE with a non-empty FIFO, rd_en is asserted 1 cycle later and the first tx_valid 3 cycles later. Back-to-back words with tx_ready tied high: 2 bytes per 4 cycles.
- en deassertion: the in-flight word always completes both bytes. A partial frame keeps its word index, and the frame resumes when en returns.
- Empty FIFO mid-frame: the block idles in IDLE with the word index retained. No tx_last is forced.
- fifo_rd_en is never asserted while fifo_empty=1 was sampled in the deciding cycle. Exactly one read is issued per word.
- frame_count wraps from 2^CNT_W-1 to 0 silently.

Test Plan:
- Write 0xA1B2 to the FIFO, en=1, tx_ready=1: exactly one fifo_rd_en pulse. Bytes 0xA1 then 0xB2. tx_last=0 (FRAME_WORDS=8). busy returns to 0.
- FRAME_WORDS=2, write 0x0102, 0x0304, 0x0506, 0x0708:
  - Byte order is 01,02,03,04,05,06,07,08.
  - tx_last is high only on bytes 04 and 08.
  - frame_count ends at 2.
- Backpressure: hold tx_ready=0 for 5 cycles during SEND_HI of 0xDEAD. tx_data stays 0xDE and tx_valid stays 1 throughout. No extra fifo_rd_en. 0xAD follows after release.
- Empty mid-frame: FRAME_WORDS=4, supply 2 words, pause, then 2 more. No tx_last until the 8th byte. No rd_en while fifo_empty=1.
- Drop en during SEND_HI: both bytes of the word are still sent, then IDLE despite a non-empty FIFO. Raising en resumes with the next word.
- Assert rst_n=0 during SEND_LO: all outputs are 0 immediately (asynchronously), frame_count=0, and state=IDLE after release.

Source files
------------

// File: rtl/fifo_byte_drain_if.sv
// Handshake bundle for fifo_byte_drain: FIFO read port plus byte stream.
// master = the drain block, slave = the FIFO/consumer side.
interface fifo_byte_drain_if;
  logic        fifo_empty;
  logic [15:0] fifo_data;
  logic        fifo_rd_en;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        tx_last;

  modport master (
    input  fifo_empty, fifo_data, tx_ready,
    output fifo_rd_en, tx_data, tx_valid, tx_last
  );

  modport slave (
    output fifo_empty, fifo_data, tx_ready,
    input  fifo_rd_en, tx_data, tx_valid, tx_last
  );
endinterface

// File: rtl/fifo_byte_drain.sv
// fifo_byte_drain: pops 16-bit words from the FIFO read port and emits them
// MSB byte first on a valid/ready byte stream, flagging the last byte of
// every FRAME_WORDS-word frame with tx_last.
module fifo_byte_drain #(
  parameter int FRAME_WORDS = 8,
  parameter int CNT_W       = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  output logic                busy,
  output logic [CNT_W-1:0]    frame_count,
  fifo_byte_drain_if.master   bus
);
  localparam int IDX_W = 8;

  typedef enum logic [2:0] {IDLE, REQ, CAPT, SEND_HI, SEND_LO} state_t;

  state_t           r_state;
  logic [15:0]      r_hold;
  logic [IDX_W-1:0] r_idx;
  logic [CNT_W-1:0] r_frame_count;
  logic             r_rd_en;
  logic [7:0]       r_tx_data;
  logic             r_tx_valid;
  logic             r_tx_last;
  logic             w_last_word;

  // Current word closes the frame.
  assign w_last_word = (r_idx == IDX_W'(FRAME_WORDS - 1));

  // Drain FSM; every output is registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_hold        <= '0;
      r_idx         <= '0;
      r_frame_count <= '0;
      r_rd_en       <= 1'b0;
      r_tx_data     <= '0;
      r_tx_valid    <= 1'b0;
      r_tx_last     <= 1'b0;
    end else begin
      r_rd_en <= 1'b0;
      case (r_state)
        IDLE: begin
          if (en && !bus.fifo_empty) begin
            r_state <= REQ;
            r_rd_en <= 1'b1;
          end
        end
        // Read strobe is out this cycle; data arrives in CAPT.
        // The empty flag lags the pop, so it is ignored here and in CAPT.
        REQ: r_state <= CAPT;
        CAPT: begin
          r_hold     <= bus.fifo_data;
          r_tx_data  <= bus.fifo_data[15:8];
          r_tx_valid <= 1'b1;
          r_tx_last  <= 1'b0;
          r_state    <= SEND_HI;
        end
        SEND_HI: begin
          if (bus.tx_ready) begin
            r_tx_data <= r_hold[7:0];
            r_tx_last <= w_last_word;
            r_state   <= SEND_LO;
          end else begin
            // Stalled: re-drive the high byte (unchanged value).
            r_tx_data <= r_hold[15:8];
          end
        end
        SEND_LO: begin
          if (bus.tx_ready) begin
            r_tx_valid <= 1'b0;
            r_tx_last  <= 1'b0;
            if (w_last_word) begin
              r_idx         <= '0;
              r_frame_count <= r_frame_count + CNT_W'(1);
            end else begin
              r_idx <= r_idx + IDX_W'(1);
            end
            // Chain straight into the next word when possible.
            if (en && !bus.fifo_empty) begin
              r_state <= REQ;
              r_rd_en <= 1'b1;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.fifo_rd_en = r_rd_en;
  assign bus.tx_data    = r_tx_data;
  assign bus.tx_valid   = r_tx_valid;
  assign bus.tx_last    = r_tx_last;
  assign busy           = (r_state != IDLE);
  assign frame_count    = r_frame_count;
endmodule

// File: tb/tb_fifo_byte_drain.sv
// Directed bench for fifo_byte_drain. Three instances with FRAME_WORDS of
// 8, 2 and 4, each fed by a small FIFO model and a byte capture monitor.
module tb_fifo_byte_drain;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        en     [3];
  logic        rdy    [3];
  logic        rd     [3];
  logic        txv    [3];
  logic        txl    [3];
  logic [7:0]  txd    [3];
  logic        busy_o [3];
  logic [7:0]  fc     [3];
  logic [15:0] fdata  [3];

  logic [15:0] mem    [3][64];
  int          wp     [3];
  int          rp     [3];
  int          rd_cnt [3];
  int          rd_bad [3];
  logic [8:0]  cap    [3][64];
  int          ncap   [3];

  int errs   = 0;
  int checks = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    fifo_byte_drain_if bus();
    assign bus.fifo_empty = (wp[g] == rp[g]);
    assign bus.fifo_data  = fdata[g];
    assign bus.tx_ready   = rdy[g];
    assign rd[g]          = bus.fifo_rd_en;
    assign txv[g]         = bus.tx_valid;
    assign txl[g]         = bus.tx_last;
    assign txd[g]         = bus.tx_data;
    fifo_byte_drain #(
      .FRAME_WORDS(g == 0 ? 8 : (g == 1 ? 2 : 4)),
      .CNT_W(8)
    ) u_dut (
      .clk(clk),
      .rst_n(rst_n),
      .en(en[g]),
      .busy(busy_o[g]),
      .frame_count(fc[g]),
      .bus(bus)
    );
  end

  // FIFO read side model plus strobe accounting and byte capture.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rd[i]) begin
        rd_cnt[i] <= rd_cnt[i] + 1;
        if (rp[i] == wp[i]) rd_bad[i] <= rd_bad[i] + 1;
        else begin
          fdata[i] <= mem[i][rp[i] & 63];
          rp[i]    <= rp[i] + 1;
        end
      end
      if (txv[i] && rdy[i]) begin
        cap[i][ncap[i] & 63] <= {txl[i], txd[i]};
        ncap[i] <= ncap[i] + 1;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input int i, input logic [15:0] w);
    mem[i][wp[i] & 63] = w;
    wp[i] = wp[i] + 1;
  endtask

  task automatic wait_idle(input int i, input int maxc);
    int n = 0;
    while (busy_o[i] && n < maxc) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy_o[i] !== 1'b0) begin
      $display("FAIL wait_idle dut%0d: busy=%b after %0d cycles, want 0", i, busy_o[i], maxc);
      errs++;
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({rd[i], txv[i], txl[i], txd[i], busy_o[i], fc[i]} !== 20'h0) begin
        $display("FAIL reset dut%0d: rd=%b v=%b l=%b d=%h busy=%b fc=%0d, want all 0",
                 i, rd[i], txv[i], txl[i], txd[i], busy_o[i], fc[i]);
        errs++;
      end
    end
  endtask

  task automatic test_single();
    int r0 = rd_cnt[0];
    int c0 = ncap[0];
    rdy[0] = 1'b1;
    en[0]  = 1'b1;
    push(0, 16'hA1B2);
    tick(1);
    checks++;
    if (rd[0] !== 1'b1) begin
      $display("FAIL single_rd_latency: rd_en=%b, want 1", rd[0]); errs++;
    end
    tick(2);
    checks++;
    if ({txv[0], txd[0]} !== 9'h1A1) begin
      $display("FAIL single_first_byte: v=%b d=%h, want v=1 d=a1", txv[0], txd[0]); errs++;
    end
    wait_idle(0, 20);
    checks++;
    if (rd_cnt[0] - r0 !== 1) begin
      $display("FAIL single_rd_count: got %0d, want 1", rd_cnt[0] - r0); errs++;
    end
    checks++;
    if (ncap[0] - c0 !== 2 || cap[0][c0] !== 9'h0A1 || cap[0][c0+1] !== 9'h0B2) begin
      $display("FAIL single_bytes: n=%0d b0=%h b1=%h, want n=2 0a1 0b2",
               ncap[0] - c0, cap[0][c0], cap[0][c0+1]); errs++;
    end
    en[0] = 1'b0;
  endtask

  task automatic test_frame();
    logic [8:0] exp [8];
    int c0 = ncap[1];
    int r0 = rd_cnt[1];
    exp = '{9'h001, 9'h002, 9'h003, 9'h104, 9'h005, 9'h006, 9'h007, 9'h108};
    rdy[1] = 1'b1;
    en[1]  = 1'b1;
    push(1, 16'h0102); push(1, 16'h0304); push(1, 16'h0506); push(1, 16'h0708);
    tick(2);
    wait_idle(1, 60);
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (cap[1][c0+k] !== exp[k]) begin
        $display("FAIL frame_byte%0d: {last,data}=%h, want %h", k, cap[1][c0+k], exp[k]); errs++;
      end
    end
    checks++;
    if (fc[1] !== 8'd2 || rd_cnt[1] - r0 !== 4) begin
      $display("FAIL frame_count: fc=%0d rd=%0d, want fc=2 rd=4", fc[1], rd_cnt[1] - r0); errs++;
    end
    en[1] = 1'b0;
  endtask

  task automatic test_backpressure();
    int r0 = rd_cnt[0];
    int c0 = ncap[0];
    rdy[0] = 1'b0;
    en[0]  = 1'b1;
    push(0, 16'hDEAD);
    tick(3);
    for (int k = 0; k < 5; k++) begin
      checks++;
      if ({txv[0], txd[0], rd[0]} !== {1'b1, 8'hDE, 1'b0}) begin
        $display("FAIL stall_cycle%0d: v=%b d=%h rd=%b, want v=1 d=de rd=0", k, txv[0], txd[0], rd[0]);
        errs++;
      end
      tick(1);
    end
    rdy[0] = 1'b1;
    wait_idle(0, 20);
    checks++;
    if (ncap[0] - c0 !== 2 || cap[0][c0] !== 9'h0DE || cap[0][c0+1] !== 9'h0AD || rd_cnt[0] - r0 !== 1) begin
      $display("FAIL stall_bytes: n=%0d b0=%h b1=%h rd=%0d, want 2 0de 0ad 1",
               ncap[0] - c0, cap[0][c0], cap[0][c0+1], rd_cnt[0] - r0); errs++;
    end
    en[0] = 1'b0;
  endtask

  task automatic test_empty_mid();
    int c0 = ncap[2];
    rdy[2] = 1'b1;
    en[2]  = 1'b1;
    push(2, 16'h1111); push(2, 16'h2222);
    tick(2);
    wait_idle(2, 40);
    checks++;
    if (ncap[2] - c0 !== 4 || cap[2][c0+3] !== 9'h022) begin
      $display("FAIL empty_half: n=%0d b3=%h, want 4 022", ncap[2] - c0, cap[2][c0+3]); errs++;
    end
    tick(5);
    push(2, 16'h3333); push(2, 16'h4444);
    tick(2);
    wait_idle(2, 40);
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (cap[2][c0+k][8] !== (k == 7)) begin
        $display("FAIL empty_last%0d: last=%b, want %b", k, cap[2][c0+k][8], (k == 7)); errs++;
      end
    end
    checks++;
    if (fc[2] !== 8'd1 || rd_bad[2] !== 0 || cap[2][c0+7] !== 9'h144) begin
      $display("FAIL empty_end: fc=%0d rd_bad=%0d b7=%h, want 1 0 144", fc[2], rd_bad[2], cap[2][c0+7]);
      errs++;
    end
  endtask

  task automatic test_en_drop();
    int c0 = ncap[1];
    int r0 = rd_cnt[1];
    rdy[1] = 1'b1;
    en[1]  = 1'b1;
    push(1, 16'h0A0B); push(1, 16'h0C0D);
    tick(3);
    en[1] = 1'b0;
    tick(4);
    checks++;
    if (busy_o[1] !== 1'b0 || ncap[1] - c0 !== 2 || rd_cnt[1] - r0 !== 1 ||
        cap[1][c0] !== 9'h00A || cap[1][c0+1] !== 9'h00B) begin
      $display("FAIL endrop_stop: busy=%b n=%0d rd=%0d b0=%h b1=%h, want 0 2 1 00a 00b",
               busy_o[1], ncap[1] - c0, rd_cnt[1] - r0, cap[1][c0], cap[1][c0+1]); errs++;
    end
    en[1] = 1'b1;
    tick(2);
    wait_idle(1, 20);
    checks++;
    if (ncap[1] - c0 !== 4 || cap[1][c0+2] !== 9'h00C || cap[1][c0+3] !== 9'h10D || fc[1] !== 8'd3) begin
      $display("FAIL endrop_resume: n=%0d b2=%h b3=%h fc=%0d, want 4 00c 10d 3",
               ncap[1] - c0, cap[1][c0+2], cap[1][c0+3], fc[1]); errs++;
    end
    en[1] = 1'b0;
  endtask

  task automatic test_reset_mid();
    rdy[2] = 1'b1;
    en[2]  = 1'b1;
    push(2, 16'h5555);
    tick(4);
    checks++;
    if ({txv[2], txd[2]} !== 9'h155) begin
      $display("FAIL rstmid_pre: v=%b d=%h, want 1 55", txv[2], txd[2]); errs++;
    end
    #2;
    rst_n  = 1'b0;
    en[2]  = 1'b0;
    #1;
    checks++;
    if ({rd[2], txv[2], txl[2], txd[2], busy_o[2], fc[2]} !== 20'h0) begin
      $display("FAIL rstmid_async: rd=%b v=%b l=%b d=%h busy=%b fc=%0d, want all 0",
               rd[2], txv[2], txl[2], txd[2], busy_o[2], fc[2]); errs++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick(2);
    checks++;
    if (busy_o[2] !== 1'b0 || txv[2] !== 1'b0 || rd[2] !== 1'b0) begin
      $display("FAIL rstmid_after: busy=%b v=%b rd=%b, want 0 0 0", busy_o[2], txv[2], rd[2]); errs++;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      en[i]  = 1'b0;
      rdy[i] = 1'b1;
    end
    tick(2);
    test_reset();
    rst_n = 1'b1;
    tick(2);
    test_single();
    test_frame();
    test_backpressure();
    test_empty_mid();
    test_en_drop();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
